// File: rtl/lsu_seq_pkg.sv
// lsu_seq_pkg
//   Shared definitions for the load/store sequencer:
//   - load and store access codes carried on req_func
//   - FSM state encoding
//   - latched request record
//   - helpers that turn an access code into a byte mask and detect whether an
//     access runs past the end of its word.
package lsu_seq_pkg;

  // Load access codes.
  localparam logic [2:0] FUNC_LB  = 3'b000;
  localparam logic [2:0] FUNC_LH  = 3'b001;
  localparam logic [2:0] FUNC_LW  = 3'b010;
  localparam logic [2:0] FUNC_LBU = 3'b100;
  localparam logic [2:0] FUNC_LHU = 3'b101;

  // Store access codes. They share the size field (bits [1:0]) with the loads;
  // req_we tells the two families apart.
  localparam logic [2:0] FUNC_SB  = 3'b000;
  localparam logic [2:0] FUNC_SH  = 3'b001;
  localparam logic [2:0] FUNC_SW  = 3'b010;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_RESP0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_RESP1 = 3'd4,
    ST_DONE  = 3'd5
  } lsu_state_e;

  // Request as captured from the MEM stage.
  typedef struct packed {
    logic        we;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Byte mask of an access, right-aligned: 0001 byte, 0011 half, 1111 word.
  // Size code 2'b11 is not a legal access and is treated as a word.
  function automatic logic [3:0] size_mask(input logic [1:0] size_code);
    logic [3:0] m;
    case (size_code)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // An access crosses into the next word when any mask bit shifts past lane 3.
  function automatic logic crosses_word(input logic [1:0] off,
                                        input logic [3:0] mask);
    logic [7:0] wide;
    wide = {4'b0000, mask} << off;
    return |wide[7:4];
  endfunction

endpackage

// File: rtl/lsu_seq_align.sv
// lsu_seq_align
//   Purely combinational byte-lane steering for lsu_seq.
//   Inputs : off    - byte offset inside the first word (addr[1:0])
//            mask   - right-aligned byte mask of the access size
//            split  - access spans two words
//            wdata  - right-aligned store data
//            rdata0 - first word read back
//            rdata1 - second word read back (ignored unless split)
//   Outputs: be0/be1       - byte enables for the first/second word
//            wdata0/wdata1 - store data moved onto the memory lanes
//            load_data     - loaded bytes realigned to bit 0, upper bytes 0
module lsu_seq_align (
  input  logic [1:0]  off,
  input  logic [3:0]  mask,
  input  logic        split,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] load_data
);

  logic [7:0]  be_wide;
  logic [5:0]  sh_lo;     // 8*off, 0..24
  logic [5:0]  sh_hi;     // 8*(4-off), 8..32
  logic [31:0] byte_mask;
  logic [31:0] hi_part;

  // Enables for both words come from one 8-lane shifted mask; the upper
  // nibble is whatever spilled past the end of the first word.
  assign be_wide = {4'b0000, mask} << off;
  assign be0     = be_wide[3:0];
  assign be1     = be_wide[7:4];

  assign sh_lo = {1'b0, off, 3'b000};
  assign sh_hi = 6'd32 - sh_lo;

  assign wdata0 = wdata << sh_lo;
  // The spill-over bytes land at the bottom of the second word.
  assign wdata1 = split ? (wdata >> sh_hi) : 32'h0;

  assign byte_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};

  // A shift by 32 would be legal but the second word only contributes when
  // the access was actually split.
  assign hi_part   = split ? (rdata1 << sh_hi) : 32'h0;
  assign load_data = ((rdata0 >> sh_lo) | hi_part) & byte_mask;

endmodule

// File: rtl/lsu_seq.sv
// lsu_seq
//   Load/store sequencer between the MEM stage and a word-addressed data
//   memory. One access per instruction; accesses crossing a word boundary are
//   split into two word transfers (or flagged via misalign when SPLIT_EN=0).
//
//   Handshake (memory side): mem_req is held high with stable mem_addr,
//   mem_be and mem_wdata until a cycle with mem_gnt=1. The sequencer then
//   waits in a response state for a cycle with mem_rvalid=1 (read data or
//   write ack). mem_rvalid is only looked at in a response state, so a grant
//   and an rvalid in the same cycle are never merged.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     req_valid/we/func/addr/wdata   MEM-stage request, held while stall=1
//     stall                freeze IF/ID/EX/MEM (combinational)
//     resp_valid           one-cycle completion pulse
//     resp_rdata           load data realigned to bit 0
//     misalign             one-cycle pulse for a refused cross-word access
//     mem_req/addr/be/wdata  memory request (registered)
//     mem_gnt, mem_rvalid, mem_rdata  memory responses
//     dbg_state, dbg_req   current FSM state and latched request
module lsu_seq
  import lsu_seq_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output lsu_state_e  dbg_state,
  output lsu_req_t    dbg_req
);

  lsu_state_e  state_q,      state_d;
  lsu_req_t    lat_q,        lat_d;
  logic [31:0] rdata0_q,     rdata0_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        misalign_q,   misalign_d;
  logic        mem_req_q,    mem_req_d;
  logic [29:0] mem_addr_q,   mem_addr_d;
  logic [3:0]  mem_be_q,     mem_be_d;
  logic [31:0] mem_wdata_q,  mem_wdata_d;

  lsu_req_t    req_in;
  lsu_req_t    cur;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic        split;
  logic [29:0] word0;
  logic [29:0] word1;
  logic [31:0] al_rdata0;
  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1;
  logic [31:0] load_data;

  assign req_in = '{we: req_we, func: req_func, addr: req_addr, wdata: req_wdata};

  // In IDLE the first word's fields are loaded straight from the incoming
  // request so REQ0 presents them in the very next cycle; afterwards
  // everything works off the latched copy.
  assign cur   = (state_q == ST_IDLE) ? req_in : lat_q;
  assign off   = cur.addr[1:0];
  assign mask  = size_mask(cur.func[1:0]);
  assign split = crosses_word(off, mask);
  assign word0 = cur.addr[31:2];
  assign word1 = word0 + 30'd1;   // wraps modulo 2^30

  // The first word is merged straight from the bus when the access is not
  // split; otherwise it comes from the register captured in RESP0.
  assign al_rdata0 = (state_q == ST_RESP0) ? mem_rdata : rdata0_q;

  lsu_seq_align u_align (
    .off       (off),
    .mask      (mask),
    .split     (split),
    .wdata     (cur.wdata),
    .rdata0    (al_rdata0),
    .rdata1    (mem_rdata),
    .be0       (be0),
    .be1       (be1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .load_data (load_data)
  );

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    rdata0_d     = rdata0_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    misalign_d   = 1'b0;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lat_d = req_in;
          if (split && !SPLIT_EN) begin
            // Refused access: report it and skip the memory entirely.
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            misalign_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d     = ST_REQ0;
            mem_req_d   = 1'b1;
            mem_addr_d  = word0;
            mem_be_d    = req_we ? be0 : 4'b0000;
            mem_wdata_d = req_we ? wdata0 : 32'h0;
          end
        end
      end

      ST_REQ0: begin
        mem_req_d = 1'b1;
        if (mem_gnt) begin
          state_d   = ST_RESP0;
          mem_req_d = 1'b0;
        end
      end

      ST_RESP0: begin
        if (mem_rvalid) begin
          rdata0_d = mem_rdata;
          if (split) begin
            state_d     = ST_REQ1;
            mem_req_d   = 1'b1;
            mem_addr_d  = word1;
            mem_be_d    = lat_q.we ? be1 : 4'b0000;
            mem_wdata_d = lat_q.we ? wdata1 : 32'h0;
          end else begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_rdata_d = lat_q.we ? 32'h0 : load_data;
          end
        end
      end

      ST_REQ1: begin
        mem_req_d = 1'b1;
        if (mem_gnt) begin
          state_d   = ST_RESP1;
          mem_req_d = 1'b0;
        end
      end

      ST_RESP1: begin
        if (mem_rvalid) begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = lat_q.we ? 32'h0 : load_data;
        end
      end

      // DONE releases the pipeline for one cycle and never accepts; the next
      // instruction is picked up from IDLE.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lat_q        <= '0;
      rdata0_q     <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      misalign_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 30'h0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      rdata0_q     <= rdata0_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      misalign_q   <= misalign_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Stall must rise in the same cycle the request appears, so it is the one
  // combinational output.
  assign stall = ((state_q == ST_IDLE) && req_valid) ||
                 (state_q == ST_REQ0) || (state_q == ST_RESP0) ||
                 (state_q == ST_REQ1) || (state_q == ST_RESP1);

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign misalign   = misalign_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_state  = state_q;
  assign dbg_req    = lat_q;

endmodule

// File: tb/tb_lsu_seq.sv
`timescale 1ns/1ps
module tb_lsu_seq;
  import lsu_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with splitting ----------------
  logic        req_valid, req_we;
  logic [2:0]  req_func;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, misalign, mem_req;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  lsu_state_e  dbg_state;
  lsu_req_t    dbg_req;

  lsu_seq #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_func(req_func),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misalign(misalign), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_req(dbg_req)
  );

  // ---------------- DUT without splitting ----------------
  logic        ns_req_valid, ns_req_we;
  logic [2:0]  ns_req_func;
  logic [31:0] ns_req_addr, ns_req_wdata;
  logic        ns_stall, ns_resp_valid, ns_misalign, ns_mem_req;
  logic [31:0] ns_resp_rdata, ns_mem_wdata;
  logic [29:0] ns_mem_addr;
  logic [3:0]  ns_mem_be;
  logic        ns_mem_gnt, ns_mem_rvalid;
  logic [31:0] ns_mem_rdata;
  lsu_state_e  ns_dbg_state;
  lsu_req_t    ns_dbg_req;

  lsu_seq #(.SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n),
    .req_valid(ns_req_valid), .req_we(ns_req_we), .req_func(ns_req_func),
    .req_addr(ns_req_addr), .req_wdata(ns_req_wdata),
    .stall(ns_stall), .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata),
    .misalign(ns_misalign), .mem_req(ns_mem_req), .mem_addr(ns_mem_addr),
    .mem_be(ns_mem_be), .mem_wdata(ns_mem_wdata), .mem_gnt(ns_mem_gnt),
    .mem_rvalid(ns_mem_rvalid), .mem_rdata(ns_mem_rdata),
    .dbg_state(ns_dbg_state), .dbg_req(ns_dbg_req)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int resp_cnt = 0;
  int mode = 1;                 // 0 random waits, 1 zero wait, 2 manual
  logic        man_gnt = 1'b0, man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  logic [33:0] exp_q[$];        // {check_rdata, misalign, rdata}
  logic [65:0] exp_req_q[$];    // {word addr, be, lane data}

  logic [31:0] mem_words [logic [29:0]];   // responder memory
  logic [7:0]  ref_bytes [logic [31:0]];   // reference byte memory

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return {a[13:0], 2'b01, a[29:14]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return init_word(a);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] ba);
    logic [31:0] w;
    if (ref_bytes.exists(ba)) return ref_bytes[ba];
    w = init_word(ba[31:2]);
    return w[8*ba[1:0] +: 8];
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic preload(input logic [29:0] w, input logic [31:0] d);
    mem_words[w] = d;
    for (int i = 0; i < 4; i++) ref_bytes[{w, i[1:0]}] = d[8*i +: 8];
  endtask

  // Reference model: walks the accessed bytes one at a time, groups them by
  // word and derives the expected word transfers and the load result.
  task automatic model_access(input logic we, input logic [2:0] func,
                              input logic [31:0] addr, input logic [31:0] wdata);
    int n, idx, lane;
    logic [29:0] wa [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    bit          used [2];
    logic [31:0] rd, ba;
    n = (func[1:0] == 2'b00) ? 1 : (func[1:0] == 2'b01) ? 2 : 4;
    wa[0] = addr[31:2]; wa[1] = '0;
    be[0] = '0; be[1] = '0; wd[0] = '0; wd[1] = '0;
    used[0] = 1'b0; used[1] = 1'b0; rd = '0;
    for (int k = 0; k < n; k++) begin
      ba   = addr + 32'(k);
      idx  = (ba[31:2] == wa[0]) ? 0 : 1;
      used[idx] = 1'b1;
      wa[idx]   = ba[31:2];
      lane = int'(ba[1:0]);
      if (we) begin
        be[idx][lane] = 1'b1;
        wd[idx][8*lane +: 8] = wdata[8*k +: 8];
        ref_bytes[ba] = wdata[8*k +: 8];
      end else begin
        rd[8*k +: 8] = ref_byte(ba);
      end
    end
    for (int j = 0; j < 2; j++)
      if (used[j]) exp_req_q.push_back({wa[j], be[j], wd[j]});
    exp_q.push_back({~we, 1'b0, rd});
  endtask

  // ---------------- memory responder / request checker ----------------
  logic        pending = 1'b0;
  logic [31:0] pend_data = 32'h0;
  logic        req_seen = 1'b0;
  logic [65:0] held = '0;

  always @(negedge clk) begin
    logic [65:0] e;
    logic [31:0] w;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (mode == 2) begin
      mem_gnt    = man_gnt;
      mem_rvalid = man_rvalid;
      mem_rdata  = man_rdata;
    end else if (pending) begin
      if (mode == 1 || $urandom_range(0, 2) != 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_data;
        pending    = 1'b0;
      end
    end else if (mem_req) begin
      if (req_seen) check("mem_hold", {mem_addr, mem_be, mem_wdata}, held);
      if (mode == 1 || $urandom_range(0, 2) == 0) begin
        mem_gnt  = 1'b1;
        req_seen = 1'b0;
        pending  = 1'b1;
        if (exp_req_q.size() == 0) begin
          check("unexpected_mem_req", {mem_addr, mem_be, mem_wdata}, '0);
        end else begin
          e = exp_req_q.pop_front();
          check("mem_addr", mem_addr, e[65:36]);
          check("mem_be", mem_be, e[35:32]);
          check("mem_wdata", mem_wdata & lane_mask(e[35:32]), e[31:0]);
        end
        w = mem_word(mem_addr);
        for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
        if (mem_be != 4'b0000) mem_words[mem_addr] = w;
        pend_data = (mem_be == 4'b0000) ? w : $urandom;
        // A stray rvalid alongside the grant must not be taken as data.
        if (mode == 0 && $urandom_range(0, 3) == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hBAD0_BAD0;
        end
      end else begin
        req_seen = 1'b1;
        held     = {mem_addr, mem_be, mem_wdata};
      end
    end else begin
      req_seen = 1'b0;
      if (mode == 0 && $urandom_range(0, 5) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {misalign, resp_rdata}, '0);
      end else begin
        e = exp_q.pop_front();
        check("misalign", misalign, e[32]);
        if (e[33]) check("resp_rdata", resp_rdata, e[31:0]);
        check("stall_at_done", stall, 1'b0);
      end
    end else if (misalign) begin
      check("misalign_without_resp", misalign, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int cycles);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  task automatic do_access(input logic we, input logic [2:0] func,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit timed, input int exp_cycles);
    int start, cyc;
    model_access(we, func, addr, wdata);
    start     = resp_cnt;
    req_valid = 1'b1;
    req_we    = we;
    req_func  = func;
    req_addr  = addr;
    req_wdata = wdata;
    if (timed) begin
      #1;
      check("stall_on_req", stall, 1'b1);
    end
    cyc = 0;
    while (resp_cnt == start && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #1;
      if (timed && resp_cnt == start) check("stall_busy", stall, 1'b1);
    end
    if (resp_cnt == start) check("resp_timeout", 1'b0, 1'b1);
    else if (timed) check("latency", 66'(cyc), 66'(exp_cycles));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        we;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [65:0] hold;
    int          r;

    req_valid = 1'b0; req_we = 1'b0; req_func = 3'b0; req_addr = '0; req_wdata = '0;
    ns_req_valid = 1'b0; ns_req_we = 1'b0; ns_req_func = 3'b0;
    ns_req_addr = '0; ns_req_wdata = '0;
    ns_mem_gnt = 1'b0; ns_mem_rvalid = 1'b0; ns_mem_rdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    mode = 1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_misalign", misalign, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 30'h0);
    check("rst_mem_be", mem_be, 4'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    idle(2);

    // Directed, zero-wait memory.
    preload(30'h40, 32'hDEAD_BEEF);
    do_access(1'b0, FUNC_LW, 32'h100, 32'h0, 1'b1, 3);
    idle(2);
    preload(30'h40, 32'h4433_2211);
    preload(30'h41, 32'h8877_6655);
    do_access(1'b0, FUNC_LW, 32'h103, 32'h0, 1'b1, 5);
    idle(2);
    do_access(1'b1, FUNC_SH, 32'h102, 32'h0000_ABCD, 1'b1, 3);
    idle(2);
    do_access(1'b1, FUNC_SW, 32'h101, 32'h1122_3344, 1'b1, 5);
    idle(2);
    do_access(1'b0, FUNC_LHU, 32'h102, 32'h0, 1'b1, 3);
    idle(2);
    do_access(1'b0, FUNC_LH, 32'hFFFF_FFFF, 32'h0, 1'b1, 5);   // word address wrap
    idle(2);

    // Randomized traffic with random grant/rvalid delays.
    mode = 0;
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      if (we) begin
        case ($urandom_range(0, 2))
          0: func = FUNC_SB;
          1: func = FUNC_SH;
          default: func = FUNC_SW;
        endcase
      end else begin
        case ($urandom_range(0, 4))
          0: func = FUNC_LB;
          1: func = FUNC_LH;
          2: func = FUNC_LW;
          3: func = FUNC_LBU;
          default: func = FUNC_LHU;
        endcase
      end
      r = $urandom_range(0, 9);
      if (r < 8)       addr = 32'h100 + 32'($urandom_range(0, 63));
      else if (r == 8) addr = $urandom;
      else             addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      do_access(we, func, addr, $urandom, 1'b0, 0);
    end
    idle(1);
    for (int t = 0; t < 500 && (exp_q.size() != 0 || exp_req_q.size() != 0); t++)
      @(negedge clk);
    check("drain_resp", 66'(exp_q.size()), 66'd0);
    check("drain_req", 66'(exp_req_q.size()), 66'd0);

    // Backpressure then reset in RESP0.
    mode = 2;
    idle(2);
    req_valid = 1'b1; req_we = 1'b0; req_func = FUNC_LW; req_addr = 32'h200;
    @(posedge clk); #1;
    check("bp_mem_req", mem_req, 1'b1);
    check("bp_mem_addr", mem_addr, 30'h80);
    check("bp_mem_be", mem_be, 4'h0);
    hold = {mem_addr, mem_be, mem_wdata};
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_req_held", mem_req, 1'b1);
      check("bp_fields_held", {mem_addr, mem_be, mem_wdata}, hold);
    end
    man_gnt = 1'b1;
    @(posedge clk); #1;
    man_gnt = 1'b0;
    check("bp_in_resp0", dbg_state, ST_RESP0);
    check("bp_req_dropped", mem_req, 1'b0);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("mid_rst_state", dbg_state, ST_IDLE);
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_outs", {resp_valid, misalign, mem_req, mem_be}, '0);
    check("mid_rst_fields", {mem_addr, mem_wdata, resp_rdata}, '0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    man_rvalid = 1'b1;
    man_rdata  = 32'h1234_5678;
    @(posedge clk); @(posedge clk); #1;
    man_rvalid = 1'b0;
    repeat (3) begin
      check("late_rvalid_ignored", {resp_valid, mem_req, resp_rdata}, '0);
      check("late_rvalid_state", dbg_state, ST_IDLE);
      @(posedge clk); #1;
    end

    // Split disabled: cross-word accesses are refused with misalign.
    @(negedge clk); #1;
    ns_req_valid = 1'b1; ns_req_we = 1'b0; ns_req_func = FUNC_LH; ns_req_addr = 32'h103;
    #1;
    check("ns_stall_on_req", ns_stall, 1'b1);
    @(posedge clk); #1;
    ns_req_valid = 1'b0;
    check("ns_misalign", ns_misalign, 1'b1);
    check("ns_resp_valid", ns_resp_valid, 1'b1);
    check("ns_mem_req", ns_mem_req, 1'b0);
    check("ns_stall_done", ns_stall, 1'b0);
    @(posedge clk); #1;
    check("ns_misalign_pulse", {ns_misalign, ns_resp_valid, ns_mem_req}, '0);
    ns_req_valid = 1'b1; ns_req_we = 1'b1; ns_req_func = FUNC_SW;
    ns_req_addr = 32'h101; ns_req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    ns_req_valid = 1'b0;
    check("ns_st_misalign", {ns_misalign, ns_resp_valid, ns_mem_req}, 3'b110);
    @(posedge clk); #1;
    check("ns_st_after", {ns_misalign, ns_resp_valid, ns_mem_req, ns_mem_be}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
